aer_spike_sender: RTL and testbench

// Downstream of the rank-order-coding encoder. Takes each sorted pixel index (NEXT_INDEX /

---
 rtl/aer_spike_sender.sv | 145 ++++++++++++++
 tb/tb_aer_spike_sender.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/aer_spike_sender.sv
// AER transmitter: turns each sorted pixel index from the rank-order encoder into one
// 4-phase REQ/ACK address-event, with back-pressure, an event counter and sticky error flags.
module aer_spike_sender #(
  parameter int ADDR_BITS      = 10,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_BITS       = 10
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [ADDR_BITS-1:0] NEXT_INDEX,
  input  logic                 FOUND_NEXT_INDEX,
  input  logic                 CNT_CLR,
  output logic                 AERIN_CTRL_BUSY,
  output logic [ADDR_BITS-1:0] AEROUT_ADDR,
  output logic                 AEROUT_REQ,
  input  logic                 AEROUT_ACK,
  output logic [CNT_BITS-1:0]  EVENT_CNT,
  output logic                 ERR_TIMEOUT,
  output logic                 ERR_OVERRUN,
  output logic [1:0]           o_dbg_state
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_REQ_HI = 2'd2,
    S_REQ_LO = 2'd3
  } state_t;

  // Handshake: REQ rises only after one cycle of stable ADDR; REQ falls once the synchronised
  // ACK is high; the event completes (BUSY falls) once the synchronised ACK is low again.
  state_t                r_state;
  logic [ADDR_BITS-1:0]  r_addr;
  logic                  r_req;
  logic                  r_busy;
  logic [CNT_BITS-1:0]   r_cnt;
  logic                  r_err_to;
  logic                  r_err_ov;
  logic                  r_ack1;
  logic                  r_ack2;
  logic [TW-1:0]         r_tmo;

  logic w_tmo_hit;
  logic w_wait_edge;
  logic w_done;
  logic w_abort;
  logic w_overrun;

  assign w_tmo_hit   = (r_tmo == TW'(TIMEOUT_CYCLES - 1));
  // True while the FSM is still waiting for the ACK edge it needs in the current state.
  assign w_wait_edge = ((r_state == S_REQ_HI) && !r_ack2) || ((r_state == S_REQ_LO) && r_ack2);
  assign w_done      = (r_state == S_REQ_LO) && !r_ack2;
  assign w_abort     = w_wait_edge && w_tmo_hit;
  assign w_overrun   = FOUND_NEXT_INDEX && (r_state != S_IDLE);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= S_IDLE;
      r_addr   <= '0;
      r_req    <= 1'b0;
      r_busy   <= 1'b0;
      r_cnt    <= '0;
      r_err_to <= 1'b0;
      r_err_ov <= 1'b0;
      r_ack1   <= 1'b0;
      r_ack2   <= 1'b0;
      r_tmo    <= '0;
    end else begin
      r_ack1 <= AEROUT_ACK;
      r_ack2 <= r_ack1;

      case (r_state)
        S_IDLE: begin
          if (FOUND_NEXT_INDEX) begin
            r_addr  <= NEXT_INDEX;
            r_busy  <= 1'b1;
            r_tmo   <= '0;
            r_state <= S_SETUP;
          end
        end
        S_SETUP: begin
          r_req   <= 1'b1;
          r_tmo   <= '0;
          r_state <= S_REQ_HI;
        end
        S_REQ_HI: begin
          if (r_ack2) begin
            r_req   <= 1'b0;
            r_tmo   <= '0;
            r_state <= S_REQ_LO;
          end else if (w_tmo_hit) begin
            r_req   <= 1'b0;
            r_busy  <= 1'b0;
            r_tmo   <= '0;
            r_state <= S_IDLE;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        S_REQ_LO: begin
          if (!r_ack2) begin
            r_busy  <= 1'b0;
            r_tmo   <= '0;
            r_state <= S_IDLE;
          end else if (w_tmo_hit) begin
            r_req   <= 1'b0;
            r_busy  <= 1'b0;
            r_tmo   <= '0;
            r_state <= S_IDLE;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        default: begin
          r_req   <= 1'b0;
          r_busy  <= 1'b0;
          r_tmo   <= '0;
          r_state <= S_IDLE;
        end
      endcase

      // Clear takes priority over a completion or error arriving in the same cycle.
      if (CNT_CLR) begin
        r_cnt    <= '0;
        r_err_to <= 1'b0;
        r_err_ov <= 1'b0;
      end else begin
        if (w_done && (r_cnt != {CNT_BITS{1'b1}})) r_cnt <= r_cnt + 1'b1;
        if (w_abort)   r_err_to <= 1'b1;
        if (w_overrun) r_err_ov <= 1'b1;
      end
    end
  end

  assign AERIN_CTRL_BUSY = r_busy;
  assign AEROUT_ADDR     = r_addr;
  assign AEROUT_REQ      = r_req;
  assign EVENT_CNT       = r_cnt;
  assign ERR_TIMEOUT     = r_err_to;
  assign ERR_OVERRUN     = r_err_ov;
  assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_aer_spike_sender.sv
// Directed bench for aer_spike_sender: single event timing, image sequence with a randomised
// ACK responder, overrun, timeout and reset-during-transfer.
module tb_aer_spike_sender;

  localparam int ADDR_BITS = 10;
  localparam int CNT_BITS  = 10;
  localparam int W         = ADDR_BITS;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [ADDR_BITS-1:0] next_index;
  logic                 found_next_index;
  logic                 cnt_clr;
  logic                 busy;
  logic [ADDR_BITS-1:0] aer_addr;
  logic                 aer_req;
  logic                 aer_ack;
  logic [CNT_BITS-1:0]  event_cnt;
  logic                 err_timeout;
  logic                 err_overrun;
  logic [1:0]           dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  aer_spike_sender #(
    .ADDR_BITS(ADDR_BITS),
    .TIMEOUT_CYCLES(16),
    .CNT_BITS(CNT_BITS)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .NEXT_INDEX(next_index),
    .FOUND_NEXT_INDEX(found_next_index),
    .CNT_CLR(cnt_clr),
    .AERIN_CTRL_BUSY(busy),
    .AEROUT_ADDR(aer_addr),
    .AEROUT_REQ(aer_req),
    .AEROUT_ACK(aer_ack),
    .EVENT_CNT(event_cnt),
    .ERR_TIMEOUT(err_timeout),
    .ERR_OVERRUN(err_overrun),
    .o_dbg_state(dbg_state)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // driver tasks: every tick returns 1 time unit after a rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_req(input logic lvl, input int limit);
    int n = 0;
    while (aer_req !== lvl && n < limit) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_busy_low(input int limit);
    int n = 0;
    while (busy !== 1'b0 && n < limit) begin
      tick();
      n++;
    end
  endtask

  task automatic pulse_clr();
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
  endtask

  task automatic strobe(input logic [W-1:0] idx);
    next_index       = idx;
    found_next_index = 1'b1;
    tick();
    found_next_index = 1'b0;
  endtask

  // Full event with an ACK responder: the address seen at REQ rise is scored against exp_q.
  task automatic send_event(input logic [W-1:0] idx, input int d_ack, input int d_rel);
    logic [W-1:0] exp_addr;
    exp_q.push_back(idx);
    strobe(idx);
    wait_req(1'b1, 20);
    check_eq("seq_req_rise", aer_req, 1'b1);
    exp_addr = exp_q.pop_front();
    check_eq("seq_addr", aer_addr, exp_addr);
    tick_n(d_ack);
    aer_ack = 1'b1;
    wait_req(1'b0, 40);
    check_eq("seq_req_fall", aer_req, 1'b0);
    tick_n(d_rel);
    aer_ack = 1'b0;
    wait_busy_low(40);
    check_eq("seq_busy_fall", busy, 1'b0);
  endtask

  logic [W-1:0] seq_idx [7];

  initial begin
    rst = 1'b1;
    next_index = '0;
    found_next_index = 1'b0;
    cnt_clr = 1'b0;
    aer_ack = 1'b0;
    tick_n(3);
    rst = 1'b0;

    // reset / idle
    tick_n(20);
    check_eq("idle_req", aer_req, 1'b0);
    check_eq("idle_busy", busy, 1'b0);
    check_eq("idle_cnt", event_cnt, 0);
    check_eq("idle_err_to", err_timeout, 1'b0);
    check_eq("idle_err_ov", err_overrun, 1'b0);
    check_eq("idle_addr", aer_addr, 0);
    check_eq("idle_state", dbg_state, 2'd0);

    // single event, cycle exact: strobe at edge 0
    strobe(10'h2A5);
    check_eq("single_addr_e0", aer_addr, 10'h2A5);
    check_eq("single_busy_e0", busy, 1'b1);
    check_eq("single_req_e0", aer_req, 1'b0);
    tick();
    check_eq("single_req_e1", aer_req, 1'b1);
    tick_n(3);
    aer_ack = 1'b1;               // ACK rises at edge 4
    tick_n(2);
    check_eq("single_req_e6", aer_req, 1'b1);
    tick();
    check_eq("single_req_e7", aer_req, 1'b0);
    check_eq("single_state_e7", dbg_state, 2'd3);
    aer_ack = 1'b0;               // ACK falls at edge 7
    tick_n(2);
    check_eq("single_busy_e9", busy, 1'b1);
    check_eq("single_cnt_e9", event_cnt, 0);
    tick();
    check_eq("single_busy_e10", busy, 1'b0);
    check_eq("single_cnt_e10", event_cnt, 1);
    check_eq("single_addr_hold", aer_addr, 10'h2A5);

    // 7-pixel image, random ACK delays, strobes one cycle after BUSY falls
    pulse_clr();
    check_eq("clr_cnt", event_cnt, 0);
    seq_idx[0] = 10'h3FF; seq_idx[1] = 10'h000; seq_idx[2] = 10'h155;
    seq_idx[3] = 10'h2AA; seq_idx[4] = 10'h001; seq_idx[5] = 10'h200;
    seq_idx[6] = 10'h0F0;
    for (int i = 0; i < 7; i++)
      send_event(seq_idx[i], $urandom_range(1, 6), $urandom_range(1, 6));
    check_eq("seq_cnt", event_cnt, 7);
    check_eq("seq_err_to", err_timeout, 1'b0);
    check_eq("seq_err_ov", err_overrun, 1'b0);
    check_eq("seq_q_empty", exp_q.size(), 0);

    // overrun: second strobe two cycles after the first
    pulse_clr();
    strobe(10'h011);
    tick();
    strobe(10'h3CC);
    check_eq("ovr_flag", err_overrun, 1'b1);
    check_eq("ovr_addr_early", aer_addr, 10'h011);
    aer_ack = 1'b1;
    wait_req(1'b0, 40);
    check_eq("ovr_req_fall", aer_req, 1'b0);
    check_eq("ovr_addr_mid", aer_addr, 10'h011);
    aer_ack = 1'b0;
    wait_busy_low(40);
    check_eq("ovr_busy_fall", busy, 1'b0);
    check_eq("ovr_cnt", event_cnt, 1);
    tick_n(10);
    check_eq("ovr_no_second_req", aer_req, 1'b0);
    check_eq("ovr_addr_end", aer_addr, 10'h011);
    check_eq("ovr_cnt_end", event_cnt, 1);

    // timeout: ACK held low, TIMEOUT_CYCLES=16
    pulse_clr();
    strobe(10'h155);
    tick();
    check_eq("to_req_e1", aer_req, 1'b1);
    tick_n(15);
    check_eq("to_req_e16", aer_req, 1'b1);
    check_eq("to_busy_e16", busy, 1'b1);
    check_eq("to_flag_e16", err_timeout, 1'b0);
    tick();
    check_eq("to_req_e17", aer_req, 1'b0);
    check_eq("to_busy_e17", busy, 1'b0);
    check_eq("to_flag_e17", err_timeout, 1'b1);
    check_eq("to_cnt", event_cnt, 0);
    check_eq("to_state", dbg_state, 2'd0);
    pulse_clr();
    check_eq("to_flag_clr", err_timeout, 1'b0);

    // reset during REQ_HI, then a fresh event
    strobe(10'h0AB);
    tick_n(3);
    check_eq("rst_pre_req", aer_req, 1'b1);
    rst = 1'b1;
    tick();
    check_eq("rst_req", aer_req, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_cnt", event_cnt, 0);
    check_eq("rst_state", dbg_state, 2'd0);
    rst = 1'b0;
    tick();
    send_event(10'h1C3, 2, 3);
    check_eq("post_rst_cnt", event_cnt, 1);
    check_eq("post_rst_flags", {err_timeout, err_overrun}, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
